// File: rtl/cpu_pkg.sv
// Constants and types shared by the CPU register file, datapath and debug blocks.
package cpu_pkg;

  localparam int NUM_REGS   = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_DRAIN,
    DUMP_READ,
    DUMP_SEND,
    DUMP_FINISH
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug register-file dumper: stalls the CPU, walks [first_addr, last_addr]
// through regfile read port 1 and streams each word out on a valid/ready link.
module regfile_dump #(
  parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  cpu_stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  import cpu_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(NUM_REGS);

  dump_state_t           state_reg;
  logic [ADDR_WIDTH-1:0] idx_reg;
  logic [ADDR_WIDTH-1:0] last_reg;
  logic                  range_bad;

  assign range_bad = (last_addr < first_addr) || (last_addr >= REG_LIMIT);

  // The read address is the walking index itself, so it comes straight from a register.
  assign rf_read_addr = idx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= DUMP_IDLE;
      idx_reg   <= '0;
      last_reg  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      cpu_stall <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_reg)
        DUMP_IDLE: begin
          if (start) begin
            last_reg  <= last_addr;
            cpu_stall <= 1'b1;
            busy      <= 1'b1;
            if (range_bad) begin
              state_reg <= DUMP_FINISH;
              done      <= 1'b1;
              error     <= 1'b1;
            end else begin
              idx_reg   <= first_addr;
              state_reg <= DUMP_DRAIN;
            end
          end
        end
        // One stalled cycle lets any in-flight CPU write land before the first read.
        DUMP_DRAIN: state_reg <= DUMP_READ;
        DUMP_READ: begin
          out_data  <= rf_read_data;
          out_index <= idx_reg;
          out_last  <= (idx_reg == last_reg);
          out_valid <= 1'b1;
          state_reg <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx_reg == last_reg) begin
              state_reg <= DUMP_FINISH;
              done      <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= DUMP_READ;
            end
          end
        end
        DUMP_FINISH: begin
          state_reg <= DUMP_IDLE;
          cpu_stall <= 1'b0;
          busy      <= 1'b0;
        end
        default: state_reg <= DUMP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump against a word-list reference model.
module tb_regfile_dump;

  localparam int NUM_REGS = 8;
  localparam int AW       = 6;
  localparam int DW       = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] index;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data;
  logic          cpu_stall;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          error;

  logic [DW-1:0] regs [0:(1<<AW)-1];
  int errors = 0;
  int checks = 0;

  assign rf_read_data = regs[rf_read_addr];

  always #5 clk = ~clk;

  regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .cpu_stall(cpu_stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .error(error)
  );

  // Runs one dump request and checks every cycle against the expected word list
  // and the cycle timing of the protocol (first word 3 cycles after start, one
  // word per 2 cycles, done the cycle after the final handshake).
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                          input int ready_pct, input int hold_first,
                          input bit poke_start, input string tag);
    word_t         exp_q[$];
    bit            bad, in_word, rdy, prev_hold, exp_busy;
    int            cyc, exp_done, next_valid, hold_cnt, words, done_cnt, n_exp;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    logic          pl;
    bad = (l < f) || (l >= AW'(NUM_REGS));
    if (!bad)
      for (int i = int'(f); i <= int'(l); i++)
        exp_q.push_back('{regs[i], AW'(i), (i == int'(l))});
    n_exp = exp_q.size();

    start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; first_addr = AW'($urandom); last_addr = AW'($urandom);
    cyc = 1; exp_done = bad ? 1 : -1; next_valid = bad ? -1 : 3;
    in_word = 0; hold_cnt = 0; words = 0; done_cnt = 0; prev_hold = 0;
    pd = '0; pi = '0; pl = 1'b0;
    forever begin
      if (!in_word && cyc == next_valid) begin
        in_word = 1; hold_cnt = 0;
      end
      exp_busy = (exp_done < 0) || (cyc <= exp_done);
      checks++;
      if (out_valid !== in_word) begin
        errors++; $display("FAIL %s valid cyc=%0d: got %b want %b", tag, cyc, out_valid, in_word);
      end
      checks++;
      if (busy !== exp_busy || cpu_stall !== exp_busy) begin
        errors++; $display("FAIL %s busy/stall cyc=%0d: got %b/%b want %b", tag, cyc, busy, cpu_stall, exp_busy);
      end
      checks++;
      if (done !== (cyc == exp_done) || error !== (bad && cyc == exp_done)) begin
        errors++; $display("FAIL %s done/error cyc=%0d: got %b/%b want %b/%b", tag, cyc, done, error,
                           (cyc == exp_done), (bad && cyc == exp_done));
      end
      if (done === 1'b1) done_cnt++;
      if (in_word && hold_cnt == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s word: got extra word idx=%0d want none", tag, out_index);
        end else if (out_data !== exp_q[0].data || out_index !== exp_q[0].index || out_last !== exp_q[0].last) begin
          errors++; $display("FAIL %s word: got %h/%0d/%b want %h/%0d/%b", tag, out_data, out_index, out_last,
                             exp_q[0].data, exp_q[0].index, exp_q[0].last);
        end
      end
      if (in_word && prev_hold) begin
        checks++;
        if (out_data !== pd || out_index !== pi || out_last !== pl) begin
          errors++; $display("FAIL %s hold cyc=%0d: got %h/%0d/%b want %h/%0d/%b", tag, cyc,
                             out_data, out_index, out_last, pd, pi, pl);
        end
      end
      if (!exp_busy) break;
      if (cyc > 400) begin
        errors++; $display("FAIL %s timeout: got no completion want done within 400 cycles", tag);
        break;
      end
      if (hold_first > 0 && words == 0) rdy = in_word && (hold_cnt >= hold_first);
      else rdy = ($urandom_range(0, 99) < ready_pct);
      out_ready = rdy;
      start = poke_start && (cyc == 2);
      if (in_word && rdy) begin
        in_word = 0; prev_hold = 0; words++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_done = cyc + 1;
        else next_valid = cyc + 2;
      end else if (in_word) begin
        prev_hold = 1; pd = out_data; pi = out_index; pl = out_last; hold_cnt++;
      end else begin
        prev_hold = 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b0;
    checks++;
    if (words != n_exp || done_cnt != 1) begin
      errors++; $display("FAIL %s totals: got words=%0d done=%0d want words=%0d done=1", tag, words, done_cnt, n_exp);
    end
    $display("dump %s first=%0d last=%0d words=%0d cycles=%0d", tag, f, l, words, cyc);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rf_read_addr, out_valid, out_data, out_index, out_last, cpu_stall, busy, done, error} !== '0) begin
      errors++; $display("FAIL reset_state: got addr=%0d v=%b d=%h i=%0d l=%b st=%b b=%b dn=%b e=%b want all zero",
                         rf_read_addr, out_valid, out_data, out_index, out_last, cpu_stall, busy, done, error);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("reset check done");
  endtask

  task automatic test_full_dump;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h10 + DW'(i);
    run_dump(0, 7, 100, 0, 0, "full");
  endtask

  task automatic test_backpressure;
    run_dump(2, 3, 100, 5, 0, "backpressure");
  endtask

  task automatic test_single;
    regs[5] = 32'hDEADBEEF;
    run_dump(5, 5, 100, 0, 0, "single");
  endtask

  task automatic test_invalid;
    run_dump(4, 2, 100, 0, 0, "invalid_order");
    run_dump(0, 8, 100, 0, 0, "invalid_limit");
  endtask

  task automatic test_reset_mid_dump;
    bit found;
    found = 0;
    start = 1'b1; first_addr = 0; last_addr = 7; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid === 1'b1 && out_index === AW'(3)) found = 1;
      else begin
        out_ready = out_valid;
        @(negedge clk);
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid reach: got no index 3 word want index 3 in SEND");
    end
    out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rf_read_addr, out_valid, out_data, out_index, out_last, cpu_stall, busy, done, error} !== '0) begin
      errors++; $display("FAIL reset_mid state: got v=%b d=%h i=%0d st=%b b=%b dn=%b want all zero",
                         out_valid, out_data, out_index, cpu_stall, busy, done);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid idle: got done=%b busy=%b valid=%b want 0/0/0", done, busy, out_valid);
      end
    end
    $display("reset mid-dump found=%0d", found);
    run_dump(3, 7, 100, 0, 0, "post_reset");
  endtask

  task automatic test_start_while_busy;
    run_dump(0, 7, 70, 0, 1, "start_busy");
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < (1 << AW); i++) regs[i] = $urandom;
      run_dump(AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)),
               $urandom_range(30, 100), 0, $urandom_range(0, 1) == 1, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) regs[i] = 32'hA5A50000 + DW'(i);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_single();
    test_invalid();
    test_reset_mid_dump();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug reader for the CPU register file. It walks a requested register range through the regfile read port and streams each word out on a valid/ready interface.
- Used by the debug/host link to snapshot architectural state.
- Stalls the CPU for the whole dump so regfile contents stay frozen.
- Sits beside the datapath and shares the regfile read port 1 through a mux controlled by cpu_stall.

Parameters:
- NUM_REGS, 8, number of implemented registers.
- ADDR_WIDTH, 6, regfile address width.
- DATA_WIDTH, 32, register word width.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_addr  input  ADDR_WIDTH  first register index, latched on accepted start.
- last_addr  input  ADDR_WIDTH  last register index (inclusive), latched on accepted start.
- rf_read_addr  output  ADDR_WIDTH  address driven to the regfile read port.
- rf_read_data  input  DATA_WIDTH  combinational regfile read data for rf_read_addr.
- cpu_stall  output  1  freezes the CPU and selects this block onto the read port.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_WIDTH  register contents.
- out_index  output  ADDR_WIDTH  register index of out_data.
- out_last  output  1  marks the final word of the dump.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the dump completes or is rejected.
- error  output  1  one-cycle pulse, coincident with done, on a rejected range.

Behaviour:
- Reset values: state IDLE, idx=0, rf_read_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, cpu_stall=0, busy=0, done=0, error=0.
- Reset has priority over every event, including mid-dump. A partially sent word is abandoned, out_valid drops the next cycle, and no done pulse is issued.
- FSM states are IDLE, DRAIN, READ, SEND, FINISH.
- IDLE:
  - On start, latch first_addr/last_addr.
  - If last_addr < first_addr or last_addr >= NUM_REGS, go to FINISH with error flagged.
  - Otherwise set idx=first_addr and go to DRAIN.
  - start in any other state is ignored; there is no queuing.
- DRAIN: one cycle with cpu_stall=1 so any in-flight CPU regfile write lands before reading. Then go to READ.
- READ:
  - rf_read_addr=idx; rf_read_data is combinational.
  - Capture out_data<=rf_read_data, out_index<=idx, out_last<=(idx==last).
  - Set out_valid<=1 and go to SEND.
  - Latency from READ to out_valid is 1 cycle.
- SEND:
  - Hold out_valid, out_data, out_index and out_last stable while out_ready=0.
  - On out_valid&&out_ready:
    - if idx==last, clear out_valid and go to FINISH;
    - else idx<=idx+1, clear out_valid and go to READ.
  - Throughput is one word per 2 cycles. Back-to-back valid is not required.
- FINISH:
  - done=1 for exactly one cycle; error=1 if the range was rejected.
  - cpu_stall deasserts on the same cycle the FSM returns to IDLE.
  - Next state is IDLE.
- cpu_stall=1 in DRAIN, READ, SEND and FINISH.
- idx never exceeds last, so there is no wrap-around. A single-register range (first==last) yields one word with out_last=1.
- out_ready asserted while out_valid=0 has no effect.
- Zero-width data is not supported. All arithmetic is unsigned ADDR_WIDTH.

Decomposition:
- Shared package cpu_pkg: state enum encoding (dump_state_t), DATA_WIDTH/ADDR_WIDTH/NUM_REGS constants. These are the same constants used by the regfile and datapath.
- No sub-module. The read-port mux (CPU address vs rf_read_addr, selected by cpu_stall) lives in the CPU top level, not in this block.

Test Plan:
- Full dump: preload r0..r7=0x10..0x17, first=0, last=7, out_ready=1.
  - 8 words with out_index 0..7 and data 0x10..0x17.
  - out_last only on index 7.
  - done pulse 1 cycle after the last handshake; busy low the next cycle.
- Backpressure: first=2, last=3, out_ready low for 5 cycles on the first word.
  - out_data=r2 held stable for all 5 cycles, then r2 and r3 delivered in order.
  - cpu_stall high throughout.
- Single register: first=last=5, r5=0xDEADBEEF.
  - One word 0xDEADBEEF, index 5, out_last=1, done=1, error=0.
- Invalid range: first=4, last=2; then separately first=0, last=8.
  - No out_valid.
  - done and error pulse together 1 cycle after start; busy high for that 1 cycle.
- Reset mid-dump: assert reset while in SEND on index 3.
  - The next cycle shows all outputs at reset values and no done pulse.
  - A new start then dumps correctly from first_addr.
- Start while busy: pulse start again during the dump.
  - It is ignored; exactly the original word count is delivered and only one done pulse occurs.
